// File: rtl/serial_word_receiver.sv
// Serial-in, parallel-out frame receiver: start bit, WIDTH data bits MSB-first, stop bit.
// The assembled word is offered on a valid/ready holding register with sticky error flags.
module serial_word_receiver #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             w,
  input  logic             bit_en,
  input  logic             out_ready,
  input  logic             err_clear,
  output logic [WIDTH-1:0] q,
  output logic             out_valid,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;

  logic good_frame;
  logic bad_frame;
  logic consume;
  logic load_word;
  logic drop_word;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      shreg <= shreg_next;
    end
  end

  // Frame sequencing advances only on qualified sample edges.
  always_comb begin
    state_next = state;
    count_next = count;
    shreg_next = shreg;
    if (bit_en) begin
      unique case (state)
        IDLE: begin
          if (!w) begin
            state_next = DATA;
            count_next = '0;
          end
        end
        DATA: begin
          shreg_next = {shreg[WIDTH-2:0], w};
          count_next = count + 1'b1;
          if (count == LAST_BIT) begin
            state_next = STOP;
          end
        end
        STOP: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  assign good_frame = bit_en && (state == STOP) && w;
  assign bad_frame  = bit_en && (state == STOP) && !w;
  assign consume    = out_valid && out_ready;
  assign load_word  = good_frame && (!out_valid || out_ready);
  assign drop_word  = good_frame && out_valid && !out_ready;

  // A load on the same edge as a consume keeps out_valid high with the new word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      q         <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load_word) begin
        q         <= shreg;
        out_valid <= 1'b1;
      end else if (consume) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky flags: a new error event on the clearing edge wins over err_clear.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (bad_frame) begin
        framing_err <= 1'b1;
      end else if (err_clear) begin
        framing_err <= 1'b0;
      end
      if (drop_word) begin
        overrun <= 1'b1;
      end else if (err_clear) begin
        overrun <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: frame-level reference model checked every
// cycle, plus literal expectations from the directed scenarios.
module tb_serial_word_receiver;

  localparam int WIDTH = 4;
  typedef logic [WIDTH-1:0] word_t;

  logic  clock;
  logic  resetn;
  logic  w;
  logic  bit_en;
  logic  out_ready;
  logic  err_clear;
  word_t q;
  logic  out_valid;
  logic  busy;
  logic  framing_err;
  logic  overrun;

  int checks   = 0;
  int failures = 0;

  serial_word_receiver #(.WIDTH(WIDTH)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .w          (w),
    .bit_en     (bit_en),
    .out_ready  (out_ready),
    .err_clear  (err_clear),
    .q          (q),
    .out_valid  (out_valid),
    .busy       (busy),
    .framing_err(framing_err),
    .overrun    (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: nbits = -1 while idle, else samples taken since the start bit.
  typedef struct packed {
    int    nbits;
    word_t word;
    word_t q;
    logic  valid;
    logic  ferr;
    logic  ovr;
  } model_t;

  localparam model_t MODEL_RESET = '{nbits: -1, word: '0, q: '0, valid: 1'b0, ferr: 1'b0, ovr: 1'b0};

  model_t m;

  function automatic model_t model_step(model_t s, logic wv, logic en, logic rdy, logic clr);
    model_t n;
    n = s;
    if (s.valid && rdy) n.valid = 1'b0;
    if (clr) begin
      n.ferr = 1'b0;
      n.ovr  = 1'b0;
    end
    if (en) begin
      if (s.nbits < 0) begin
        if (!wv) begin
          n.nbits = 0;
          n.word  = '0;
        end
      end else if (s.nbits < WIDTH) begin
        n.word  = word_t'(int'(s.word) * 2 + int'(wv));
        n.nbits = s.nbits + 1;
      end else begin
        if (wv) begin
          if (!s.valid || rdy) begin
            n.q     = s.word;
            n.valid = 1'b1;
          end else begin
            n.ovr = 1'b1;
          end
        end else begin
          n.ferr = 1'b1;
        end
        n.nbits = -1;
      end
    end
    return n;
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) m <= MODEL_RESET;
    else         m <= model_step(m, w, bit_en, out_ready, err_clear);
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare process: every falling edge while out of reset.
  always @(negedge clock) begin
    if (resetn) begin
      check_output("cyc_q", 32'(q), 32'(m.q));
      check_output("cyc_out_valid", 32'(out_valid), 32'(m.valid));
      check_output("cyc_busy", 32'(busy), 32'(m.nbits >= 0));
      check_output("cyc_framing_err", 32'(framing_err), 32'(m.ferr));
      check_output("cyc_overrun", 32'(overrun), 32'(m.ovr));
    end
  end

  // Inputs are applied 2 time units after a posedge and sampled at the next posedge;
  // the task returns 2 units after that edge, so outputs reflect this sample.
  task automatic apply_stimulus(input logic wv, input logic en, input logic rdy, input logic clr);
    w         = wv;
    bit_en    = en;
    out_ready = rdy;
    err_clear = clr;
    @(posedge clock);
    #2;
  endtask

  task automatic idle_cycle(input logic rdy, input logic clr);
    apply_stimulus(1'b1, 1'b1, rdy, clr);
  endtask

  task automatic send_frame(input word_t data, input logic stop_bit, input logic rdy_on_stop);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = WIDTH - 1; i >= 0; i--) apply_stimulus(data[i], 1'b1, 1'b0, 1'b0);
    apply_stimulus(stop_bit, 1'b1, rdy_on_stop, 1'b0);
  endtask

  initial begin
    int busy_cycles;
    word_t c_word;
    resetn    = 1'b0;
    w         = 1'b1;
    bit_en    = 1'b0;
    out_ready = 1'b0;
    err_clear = 1'b0;
    #12;
    check_output("rst_q", 32'(q), 32'h0);
    check_output("rst_out_valid", 32'(out_valid), 32'h0);
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_framing_err", 32'(framing_err), 32'h0);
    check_output("rst_overrun", 32'(overrun), 32'h0);
    @(posedge clock);
    #2;
    resetn = 1'b1;
    idle_cycle(1'b0, 1'b0);

    // 1: basic frame 4'hB, count busy cycles
    busy_cycles = 0;
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    if (busy) busy_cycles++;
    for (int i = 0; i < 4; i++) begin
      apply_stimulus((i != 1), 1'b1, 1'b0, 1'b0);
      if (busy) busy_cycles++;
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    if (busy) busy_cycles++;
    check_output("t1_q", 32'(q), 32'hB);
    check_output("t1_out_valid", 32'(out_valid), 32'h1);
    check_output("t1_busy_cycles", 32'(busy_cycles), 32'd5);
    check_output("t1_framing_err", 32'(framing_err), 32'h0);
    check_output("t1_overrun", 32'(overrun), 32'h0);
    idle_cycle(1'b1, 1'b0);
    check_output("t1_consumed", 32'(out_valid), 32'h0);

    // 2: back-pressure and overrun
    send_frame(4'hA, 1'b1, 1'b0);
    idle_cycle(1'b0, 1'b0);
    send_frame(4'h5, 1'b1, 1'b0);
    check_output("t2_q_held", 32'(q), 32'hA);
    check_output("t2_out_valid", 32'(out_valid), 32'h1);
    check_output("t2_overrun", 32'(overrun), 32'h1);
    idle_cycle(1'b1, 1'b0);
    check_output("t2_consumed", 32'(out_valid), 32'h0);
    idle_cycle(1'b0, 1'b1);
    check_output("t2_overrun_clr", 32'(overrun), 32'h0);

    // 3: framing error, then a good frame with the flag still set
    send_frame(4'hC, 1'b0, 1'b0);
    check_output("t3_out_valid", 32'(out_valid), 32'h0);
    check_output("t3_q", 32'(q), 32'hA);
    check_output("t3_framing_err", 32'(framing_err), 32'h1);
    check_output("t3_busy", 32'(busy), 32'h0);
    idle_cycle(1'b0, 1'b0);
    send_frame(4'h3, 1'b1, 1'b0);
    check_output("t3_q_good", 32'(q), 32'h3);
    check_output("t3_framing_err_kept", 32'(framing_err), 32'h1);
    idle_cycle(1'b1, 1'b1);
    check_output("t3_framing_err_clr", 32'(framing_err), 32'h0);

    // 4: strobed sampling every 3rd cycle, frame 4'hC
    c_word = 4'hC;
    for (int b = 0; b < WIDTH + 2; b++) begin
      logic bv;
      bv = (b == 0) ? 1'b0 : (b == WIDTH + 1) ? 1'b1 : c_word[WIDTH - b];
      apply_stimulus(bv, 1'b1, 1'b0, 1'b0);
      apply_stimulus(bv, 1'b0, 1'b0, 1'b0);
      apply_stimulus(bv, 1'b0, 1'b0, 1'b0);
    end
    check_output("t4_q", 32'(q), 32'hC);
    check_output("t4_out_valid", 32'(out_valid), 32'h1);
    idle_cycle(1'b1, 1'b0);

    // 5: async reset mid-frame
    send_frame(4'h1, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_output("t5_busy_before", 32'(busy), 32'h1);
    w = 1'b1;
    resetn = 1'b0;
    #1;
    check_output("t5_rst_busy", 32'(busy), 32'h0);
    check_output("t5_rst_q", 32'(q), 32'h0);
    check_output("t5_rst_out_valid", 32'(out_valid), 32'h0);
    #1;
    resetn = 1'b1;
    @(posedge clock);
    #2;
    send_frame(4'h9, 1'b1, 1'b0);
    check_output("t5_q", 32'(q), 32'h9);
    idle_cycle(1'b1, 1'b0);

    // 6: consume and load on the same edge
    send_frame(4'h1, 1'b1, 1'b0);
    check_output("t6_q_first", 32'(q), 32'h1);
    send_frame(4'hE, 1'b1, 1'b1);
    check_output("t6_out_valid", 32'(out_valid), 32'h1);
    check_output("t6_q", 32'(q), 32'hE);
    check_output("t6_overrun", 32'(overrun), 32'h0);
    idle_cycle(1'b1, 1'b0);
    idle_cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
